sram_dp_param: RTL
==================

Name: sram_dp_param

Overview:
Parametrised single-clock true dual-port SRAM model used by the image-processing datapaths as a frame/line store. It generalises data width and depth and defines same-cycle port collisions. A reset-triggered and request-triggered clear engine zeroes the array, and a busy flag gates access while the clear runs.

Parameters:
DATA_W, 8, data width in bits per word
ADDR_W, 16, address width; depth = 2**ADDR_W words
CLEAR_ON_RESET, 1, 1 = clear engine starts automatically on reset release; 0 = array holds X/contents until clr_req

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr_req  input  1  one-cycle pulse; starts a full-array clear
busy  output  1  high while the clear engine runs
ena  input  1  port A enable, active high
wena  input  1  port A write enable, active low (0 = write, 1 = read)
addra  input  ADDR_W  port A address
da  input  DATA_W  port A write data
qa  output  DATA_W  port A read data, registered
enb  input  1  port B enable, active high
wenb  input  1  port B write enable, active low
addrb  input  ADDR_W  port B address
db  input  DATA_W  port B write data
qb  output  DATA_W  port B read data, registered
coll  output  1  one-cycle pulse: both ports wrote the same address in one cycle

Behaviour:
- Reset (rst_n=0, async): qa=0, qb=0, coll=0, clear counter=0. busy=CLEAR_ON_RESET. FSM -> CLEAR if CLEAR_ON_RESET=1, else IDLE. Array contents are not reset asynchronously.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, counter=0, busy=1 from the next cycle.
  - CLEAR: writes 0 to mem[counter] and increments the counter, one word per clock. At counter=2**ADDR_W-1 it writes the last word and returns to IDLE. busy falls the cycle after the last word is written.
  - The clear takes exactly 2**ADDR_W cycles.
  - clr_req during CLEAR is ignored; the counter does not restart.
- While busy=1:
  - ena/enb are ignored: no writes, qa/qb hold their values, coll=0.
- Read (en=1, wen=1):
  - q updates on the next rising edge to mem[addr].
  - Latency 1 cycle. q holds when en=0.
- Write (en=1, wen=0):
  - mem[addr] <= d.
  - The same port's q is write-first: q shows d on the next edge.
- Cross-port, same address, same cycle:
  - A writes, B reads: qb returns the OLD word (read-first across ports). The B->A case is symmetric.
  - Both write: port A data wins and coll=1 for exactly one cycle. qa=da and qb=da next cycle, because the port B output reflects the resolved word.
  - Both read: both return the same word, no side effects.
- Different addresses: the two ports are fully independent, one access per port per cycle.
- Address is always in range; there is no wrap logic beyond ADDR_W bits.
- Reset asserted mid-CLEAR: the FSM restarts per the reset rules. Partially cleared words stay at 0 and the remaining words keep their old values if CLEAR_ON_RESET=0.

Optional Feature:
- Macro: SRAM_DP_OUT_REG_EN.
- Defined:
  - Adds a second output register stage on qa and qb. Read/write-first latency becomes 2 cycles.
  - The stage is reset to 0 and advances every cycle regardless of en, so held data propagates.
  - coll is delayed one extra cycle so it aligns with qa/qb.
- Undefined: latency 1 as described above and no extra flops.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_W=4 -> busy=1 for exactly 16 cycles after rst_n rises. After that, reading addresses 0..15 returns 0x00 on both ports.
- Port A write 0xA5@0x3, then port B read 0x3 next cycle -> qb=0xA5 one cycle after the read (two cycles with SRAM_DP_OUT_REG_EN).
- Same cycle: A writes 0x5A@0x7 while B reads 0x7, which holds 0x11 -> qb=0x11. A following B read of 0x7 -> 0x5A.
- Same cycle: A writes 0x33@0x2 and B writes 0xCC@0x2 -> coll=1 for one cycle, qa=qb=0x33, and a later read of 0x2 returns 0x33.
- Fill with 0xFF, pulse clr_req, and issue writes and a second clr_req during busy -> writes are ignored, busy lasts exactly 16 cycles, and all words read 0x00 after.
- Assert rst_n=0 at clear cycle 5 of 16 -> qa=qb=0 immediately, and the clear restarts from counter 0 after release.

Source files
------------

// File: rtl/sram_dp_param_if.sv
// Bus bundle for sram_dp_param: clear control, busy flag, and the two RAM ports.
// The master side drives requests; the slave side is the memory.
interface sram_dp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              clr_req;
  logic              busy;
  logic              ena;
  logic              wena;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] da;
  logic [DATA_W-1:0] qa;
  logic              enb;
  logic              wenb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] db;
  logic [DATA_W-1:0] qb;
  logic              coll;

  modport master (
    output clr_req, ena, wena, addra, da, enb, wenb, addrb, db,
    input  busy, qa, qb, coll
  );

  modport slave (
    input  clr_req, ena, wena, addra, da, enb, wenb, addrb, db,
    output busy, qa, qb, coll
  );
endinterface

// File: rtl/sram_dp_param.sv
// Single-clock true dual-port SRAM with collision resolution and a sequential clear engine.
// Optional macro SRAM_DP_OUT_REG_EN adds a second output register stage on qa/qb/coll.
module sram_dp_param #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic            clk,
  input logic            rst_n,
  sram_dp_param_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic [0:0] RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              busy;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_a;
  logic              acc_b;
  logic              wr_a;
  logic              wr_b;
  logic              same_addr;
  logic              wr_b_mem;
  logic              coll_nxt;
  logic [DATA_W-1:0] wdata_b;

  logic [DATA_W-1:0] q1a;
  logic [DATA_W-1:0] q1b;
  logic              coll1;

  assign busy = (state == CLEAR);

  // Port decode; any access is suppressed while the clear engine owns the array.
  always_comb begin
    acc_a     = bus.ena & ~busy;
    acc_b     = bus.enb & ~busy;
    wr_a      = acc_a & ~bus.wena;
    wr_b      = acc_b & ~bus.wenb;
    same_addr = (bus.addra == bus.addrb);
    wr_b_mem  = wr_b & ~(wr_a & same_addr);
    coll_nxt  = wr_a & wr_b & same_addr;
    wdata_b   = (wr_a & same_addr) ? bus.da : bus.db;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == '1) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Array has no reset; writes are blocked while rst_n is low so a reset
  // landing mid-clear leaves the untouched words intact.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy) begin
        mem[cnt] <= '0;
      end else begin
        if (wr_a) begin
          mem[bus.addra] <= bus.da;
        end
        if (wr_b_mem) begin
          mem[bus.addrb] <= bus.db;
        end
      end
    end
  end

  // Same-port write-first, cross-port read-first; a B write shows the resolved word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1a   <= '0;
      q1b   <= '0;
      coll1 <= 1'b0;
    end else begin
      coll1 <= coll_nxt;
      if (acc_a) begin
        q1a <= wr_a ? bus.da : mem[bus.addra];
      end
      if (acc_b) begin
        q1b <= wr_b ? wdata_b : mem[bus.addrb];
      end
    end
  end

`ifdef SRAM_DP_OUT_REG_EN
  logic [DATA_W-1:0] q2a;
  logic [DATA_W-1:0] q2b;
  logic              coll2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2a   <= '0;
      q2b   <= '0;
      coll2 <= 1'b0;
    end else begin
      q2a   <= q1a;
      q2b   <= q1b;
      coll2 <= coll1;
    end
  end

  assign bus.qa   = q2a;
  assign bus.qb   = q2b;
  assign bus.coll = coll2;
`else
  assign bus.qa   = q1a;
  assign bus.qb   = q1b;
  assign bus.coll = coll1;
`endif

  assign bus.busy = busy;

endmodule
